// File: rtl/shift_seq8_pkg.sv
// shift_seq8_pkg -- shared encodings for the shift sequencer and its bench.
//   OP_*    : step opcode driven on op (applied at the next clock edge)
//   CMD_*   : shift type accepted on cmd
//   state_t : sequencer FSM state encoding
//   cmd_to_op : maps a captured command to the per-step opcode
//   step_amt  : amount of one step, min(remaining, 3)
package shift_seq8_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  localparam logic [1:0] CMD_LSL  = 2'b00;
  localparam logic [1:0] CMD_LSR  = 2'b01;
  localparam logic [1:0] CMD_ASR  = 2'b10;
  localparam logic [1:0] CMD_PASS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  function automatic logic [2:0] cmd_to_op(input logic [1:0] c);
    logic [2:0] o;
    case (c)
      CMD_LSL: o = OP_LSL;
      CMD_LSR: o = OP_LSR;
      CMD_ASR: o = OP_ASR;
      default: o = OP_NOP;
    endcase
    return o;
  endfunction

  function automatic logic [1:0] step_amt(input logic [2:0] rem);
    return (rem >= 3'd3) ? 2'd3 : rem[1:0];
  endfunction

endpackage

// File: rtl/shift_step8.sv
// shift_step8 -- purely combinational single-step shifter.
//   op    in  3 : step opcode (LSL/LSR/ASR shift, anything else passes d_cur)
//   shamt in  2 : step amount 0..3
//   d_cur in  8 : current data
//   d_nxt out 8 : data after this step, truncated to 8 bits
module shift_step8
  import shift_seq8_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] shamt,
  input  logic [7:0] d_cur,
  output logic [7:0] d_nxt
);

  always_comb begin
    d_nxt = d_cur;
    case (op)
      OP_LSL:  d_nxt = d_cur << shamt;
      OP_LSR:  d_nxt = d_cur >> shamt;
      // Arithmetic shift replicates bit 7 into the vacated positions.
      OP_ASR:  d_nxt = $unsigned($signed(d_cur) >>> shamt);
      default: d_nxt = d_cur;
    endcase
  end

endmodule

// File: rtl/shift_seq8.sv
// shift_seq8 -- multi-step shift sequencer: captures a command, loads the
// operand, then shifts it in steps of at most 3 until the amount is used up.
//   clk     in  1 : rising-edge clock
//   reset_n in  1 : asynchronous active-low reset
//   start   in  1 : command request, sampled only in IDLE
//   cmd     in  2 : shift type (LSL/LSR/ASR, 11 = pass-through)
//   amt     in  3 : total shift amount 0..7
//   d_in    in  8 : operand, captured with start
//   busy    out 1 : high outside IDLE
//   done    out 1 : one-cycle pulse in DONE
//   d_out   out 8 : data register
//   op      out 3 : step opcode applied at the next edge
//   shamt   out 2 : step amount applied at the next edge
module shift_seq8
  import shift_seq8_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [2:0] amt,
  input  logic [7:0] d_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] d_out,
  output logic [2:0] op,
  output logic [1:0] shamt
);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] cmd_reg;
  logic [7:0] operand_reg;
  logic [2:0] remaining_reg;
  logic [7:0] d_out_reg;
  logic [7:0] d_nxt;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD:  state_next = (remaining_reg == 3'd0) ? ST_DONE : ST_SHIFT;
      // Last step is the one that consumes everything that is left.
      ST_SHIFT: if (remaining_reg == {1'b0, shamt}) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    op    = OP_NOP;
    shamt = 2'd0;
    busy  = (state_reg != ST_IDLE);
    done  = (state_reg == ST_DONE);
    case (state_reg)
      ST_LOAD: op = OP_LOAD;
      ST_SHIFT: begin
        op    = cmd_to_op(cmd_reg);
        shamt = step_amt(remaining_reg);
      end
      default: ;
    endcase
  end

  shift_step8 u_step (
    .op    (op),
    .shamt (shamt),
    .d_cur (d_out_reg),
    .d_nxt (d_nxt)
  );

  // Command capture, remaining counter and data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_reg       <= CMD_LSL;
      operand_reg   <= 8'h00;
      remaining_reg <= 3'd0;
      d_out_reg     <= 8'h00;
    end else begin
      // Capture happens only in IDLE, so start while busy cannot disturb it.
      if (state_reg == ST_IDLE && start) begin
        cmd_reg       <= cmd;
        operand_reg   <= d_in;
        remaining_reg <= (cmd == CMD_PASS) ? 3'd0 : amt;
      end
      if (state_reg == ST_SHIFT)
        remaining_reg <= remaining_reg - {1'b0, shamt};
      // NOP steps pass d_out_reg through the shifter, so one mux covers hold.
      d_out_reg <= (op == OP_LOAD) ? operand_reg : d_nxt;
    end
  end

  assign d_out = d_out_reg;

endmodule

// File: doc/shift_seq8.md
SHIFT_SEQ8 -- requirements
Module: shift_seq8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and reset_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  command request, sampled only in IDLE.
REQ-005 cmd  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 reserved (pass-through).
REQ-006 amt  in  3  total shift amount, 0..7.
REQ-007 d_in  in  8  operand, captured with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse, high in DONE state only.
REQ-010 d_out  out  8  data register.
REQ-011 op  out  3  step opcode applied at next edge: NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100.
REQ-012 shamt  out  2  step amount applied at next edge, 0..3.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-014 In IDLE with start=1 at edge E0, the block SHALL capture cmd, amt and d_in, and SHALL go to LOAD.
REQ-015 In IDLE with start=0, the block SHALL hold d_out, and SHALL drive op=NOP and shamt=0.
REQ-016 In LOAD the block SHALL drive op=LOAD; at E1 d_out SHALL take the captured operand, and the next state SHALL be SHIFT, or DONE if the effective amount is 0.
REQ-017 The effective amount SHALL equal amt, except that it SHALL be 0 when cmd=11.
REQ-018 In SHIFT the block SHALL drive op per cmd and shamt = min(remaining, 3), and SHALL decrement remaining by shamt at each edge; step order for 7 SHALL be 3,3,1.
REQ-019 When remaining reaches 0, SHIFT SHALL go to DONE.
REQ-020 The number of shift steps SHALL be k = ceil(amt/3).
REQ-021 Shifts SHALL occur at edges E2..E(1+k), and done SHALL be high for the cycle following E(1+k).
REQ-022 LSL and LSR SHALL fill with 0, and ASR SHALL replicate bit 7; all results SHALL be truncated to 8 bits.
REQ-023 DONE SHALL drive op=NOP, SHALL return to IDLE at the next edge, and d_out SHALL hold the result until the next LOAD.
REQ-024 start while busy (including the DONE cycle) SHALL be ignored, and captured cmd, amt and operand SHALL NOT change.
REQ-025 A new command SHALL be accepted no earlier than the first IDLE cycle after DONE.

Reset
REQ-026 reset_n=0 SHALL force IDLE, d_out=0x00, busy=0, done=0, op=NOP, shamt=0, and remaining=0 immediately, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL abort the command, and no done pulse SHALL follow.
REQ-028 After reset release, the first start SHALL be accepted at the next rising edge.

Structure
REQ-029 Opcode values, cmd encodings and FSM state encodings SHALL live in a shared parameter include file, used by the RTL and the bench.
REQ-030 The one-step shift datapath SHALL be one combinational sub-module, shift_step8 (inputs op, shamt, d_cur; output d_nxt).
REQ-031 The FSM, the remaining counter and the d_out register SHALL live in shift_seq8.

Verification
REQ-032 LSL, amt=5, d_in=0x03 -> steps 3,2; d_out=0x60; done high in the cycle after E3.
REQ-033 ASR, amt=7, d_in=0x80 -> steps 3,3,1; d_out=0xFF; done after E4.
REQ-034 LSR, amt=4, d_in=0xF0 -> d_out=0x0F; also run ASR, amt=4, d_in=0x70 -> 0x07.
REQ-035 amt=0 (cmd=00) and cmd=11 (amt=6), d_in=0xA5 -> no SHIFT state; d_out=0xA5; done after E1.
REQ-036 start pulsed during SHIFT and during DONE with d_in=0x11 -> ignored; the result of the original command is unchanged, and busy=0 after DONE.
REQ-037 reset_n low during SHIFT of LSL amt=7 -> immediate d_out=0x00, busy=0, done never pulses; a subsequent command completes normally.
